// File: rtl/pixel_array_ctrl_if.sv
// Output stream of the pixel array controller: one captured row code per beat,
// valid/ready handshake. The controller is the master.
interface pixel_array_ctrl_if #(
    parameter int unsigned ROWS = 2,
    parameter int unsigned DW   = 8
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for an N-row digital pixel array: erase, expose, single-slope
// conversion (ramp code on the shared bus), then row-by-row readout onto a
// valid/ready stream with backpressure. All outputs are registered.
// Optional build macro PIXCTRL_CONT_EN: start acts as a run level and DONE
// chains straight into the next frame's ERASE while start stays high.
module pixel_array_ctrl #(
    parameter int unsigned ROWS     = 2,
    parameter int unsigned DW       = 8,
    parameter int unsigned C_ERASE  = 5,
    parameter int unsigned C_EXPOSE = 255,
    parameter int unsigned C_READ   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            erase,
    output logic            expose,
    output logic            convert,
    output logic [ROWS-1:0] read_sel,
    output logic            bus_oe,
    output logic [DW-1:0]   bus_out,
    input  logic [DW-1:0]   bus_in,
    output logic            frame_done,
    pixel_array_ctrl_if.master strm
);
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned C_CONV  = 32'd1 << DW;
    localparam int unsigned M_EX    = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
    localparam int unsigned M_EXR   = (M_EX > C_READ) ? M_EX : C_READ;
    localparam int unsigned MAX_DUR = (M_EXR > C_CONV) ? M_EXR : C_CONV;
    localparam int unsigned CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ERASE   = 4'd1;
    localparam logic [3:0] S_GAP1    = 4'd2;
    localparam logic [3:0] S_EXPOSE  = 4'd3;
    localparam logic [3:0] S_GAP2    = 4'd4;
    localparam logic [3:0] S_CONVERT = 4'd5;
    localparam logic [3:0] S_GAP3    = 4'd6;
    localparam logic [3:0] S_READ    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic            capture;

    logic            busy_nxt, erase_nxt, expose_nxt, convert_nxt;
    logic            bus_oe_nxt, frame_done_nxt;
    logic [ROWS-1:0] read_sel_nxt;
    logic [DW-1:0]   bus_out_nxt;
    logic [DW-1:0]   out_data_nxt;
    logic [RW-1:0]   out_row_nxt;
    logic            out_valid_nxt;

    // Next-state, phase counter and registered-output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        capture   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ERASE;
                    cnt_nxt   = '0;
                end
            end
            S_ERASE: begin
                if (cnt == CW'(C_ERASE - 1)) begin
                    state_nxt = S_GAP1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP1: begin
                state_nxt = S_EXPOSE;
                cnt_nxt   = '0;
            end
            S_EXPOSE: begin
                if (cnt == CW'(C_EXPOSE - 1)) begin
                    state_nxt = S_GAP2;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP2: begin
                state_nxt = S_CONVERT;
                cnt_nxt   = '0;
            end
            S_CONVERT: begin
                if (cnt == CW'(C_CONV - 1)) begin
                    state_nxt = S_GAP3;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP3: begin
                state_nxt = S_READ;
                cnt_nxt   = '0;
                row_nxt   = '0;
            end
            S_READ: begin
                if (cnt == CW'(C_READ - 1)) begin
                    // Last window cycle: hold here until the output register can take the code
                    if (!strm.out_valid || strm.out_ready) begin
                        capture = 1'b1;
                        cnt_nxt = '0;
                        if (row == RW'(ROWS - 1)) begin
                            state_nxt = S_DONE;
                            row_nxt   = '0;
                        end else begin
                            row_nxt = row + RW'(1);
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                cnt_nxt = '0;
`ifdef PIXCTRL_CONT_EN
                state_nxt = start ? S_ERASE : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                row_nxt   = '0;
            end
        endcase

        busy_nxt       = (state_nxt != S_IDLE);
        erase_nxt      = (state_nxt == S_ERASE);
        expose_nxt     = (state_nxt == S_EXPOSE);
        convert_nxt    = (state_nxt == S_CONVERT);
        bus_oe_nxt     = (state_nxt == S_CONVERT);
        bus_out_nxt    = (state_nxt == S_CONVERT) ? DW'(cnt_nxt) : '0;
        read_sel_nxt   = (state_nxt == S_READ) ? (ROWS'(1) << row_nxt) : '0;
        frame_done_nxt = (state_nxt == S_DONE);

        out_data_nxt  = strm.out_data;
        out_row_nxt   = strm.out_row;
        out_valid_nxt = strm.out_valid;
        if (capture) begin
            out_data_nxt  = bus_in;
            out_row_nxt   = row;
            out_valid_nxt = 1'b1;
        end else if (strm.out_valid && strm.out_ready) begin
            out_data_nxt  = '0;
            out_row_nxt   = '0;
            out_valid_nxt = 1'b0;
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            row            <= '0;
            busy           <= 1'b0;
            erase          <= 1'b0;
            expose         <= 1'b0;
            convert        <= 1'b0;
            bus_oe         <= 1'b0;
            bus_out        <= '0;
            read_sel       <= '0;
            frame_done     <= 1'b0;
            strm.out_data  <= '0;
            strm.out_row   <= '0;
            strm.out_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            row            <= row_nxt;
            busy           <= busy_nxt;
            erase          <= erase_nxt;
            expose         <= expose_nxt;
            convert        <= convert_nxt;
            bus_oe         <= bus_oe_nxt;
            bus_out        <= bus_out_nxt;
            read_sel       <= read_sel_nxt;
            frame_done     <= frame_done_nxt;
            strm.out_data  <= out_data_nxt;
            strm.out_row   <= out_row_nxt;
            strm.out_valid <= out_valid_nxt;
        end
    end
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: a main instance (ROWS=2, DW=4) and an
// edge instance (ROWS=1, DW=2, all durations 1), stream beats scored against a queue.
module tb_pixel_array_ctrl;
    typedef struct packed {
        logic       busy;
        logic       erase;
        logic       expose;
        logic       convert;
        logic       bus_oe;
        logic [7:0] code;
        logic [1:0] sel;
        logic       done;
        logic       valid;
        logic [1:0] row;
    } ctl_t;

    typedef struct {
        int row;
        int data;
    } beat_t;

    logic clk;
    logic reset;

    // main instance signals
    logic       m_start, m_busy, m_erase, m_expose, m_convert, m_bus_oe, m_frame_done;
    logic [1:0] m_read_sel;
    logic [3:0] m_bus_out, m_bus_in;
    // edge instance signals
    logic       e_start, e_busy, e_erase, e_expose, e_convert, e_bus_oe, e_frame_done;
    logic [0:0] e_read_sel;
    logic [1:0] e_bus_out, e_bus_in;

    pixel_array_ctrl_if #(.ROWS(2), .DW(4)) sif_m ();
    pixel_array_ctrl_if #(.ROWS(1), .DW(2)) sif_e ();

    pixel_array_ctrl #(.ROWS(2), .DW(4), .C_ERASE(5), .C_EXPOSE(10), .C_READ(3)) dut_m (
        .clk(clk), .reset(reset), .start(m_start), .busy(m_busy), .erase(m_erase),
        .expose(m_expose), .convert(m_convert), .read_sel(m_read_sel), .bus_oe(m_bus_oe),
        .bus_out(m_bus_out), .bus_in(m_bus_in), .frame_done(m_frame_done), .strm(sif_m.master)
    );

    pixel_array_ctrl #(.ROWS(1), .DW(2), .C_ERASE(1), .C_EXPOSE(1), .C_READ(1)) dut_e (
        .clk(clk), .reset(reset), .start(e_start), .busy(e_busy), .erase(e_erase),
        .expose(e_expose), .convert(e_convert), .read_sel(e_read_sel), .bus_oe(e_bus_oe),
        .bus_out(e_bus_out), .bus_in(e_bus_in), .frame_done(e_frame_done), .strm(sif_e.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel models: each pixel latches the ramp code equal to its threshold; erase clears it
    logic [3:0] th_m0, th_m1, lat_m0, lat_m1;
    logic [1:0] th_e, lat_e;
    always @(posedge clk) begin
        if (m_erase) begin
            lat_m0 <= 4'h0;
            lat_m1 <= 4'h0;
        end else if (m_convert) begin
            if (m_bus_out == th_m0) lat_m0 <= m_bus_out;
            if (m_bus_out == th_m1) lat_m1 <= m_bus_out;
        end
        if (e_erase) lat_e <= 2'h0;
        else if (e_convert && e_bus_out == th_e) lat_e <= e_bus_out;
    end
    assign m_bus_in = m_read_sel[0] ? lat_m0 : (m_read_sel[1] ? lat_m1 : 4'h0);
    assign e_bus_in = e_read_sel[0] ? lat_e : 2'h0;

    ctl_t obs_m, obs_e;
    assign obs_m = {m_busy, m_erase, m_expose, m_convert, m_bus_oe, 8'(m_bus_out), 2'(m_read_sel),
                    m_frame_done, sif_m.out_valid, 2'(sif_m.out_row)};
    assign obs_e = {e_busy, e_erase, e_expose, e_convert, e_bus_oe, 8'(e_bus_out), 2'(e_read_sel),
                    e_frame_done, sif_e.out_valid, 2'(sif_e.out_row)};

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    dones;
    bit    fin;
`ifdef PIXCTRL_CONT_EN
    bit    exp_erase;
`endif
    beat_t sb_m[$];
    beat_t sb_e[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_m(input int r, input int d);
        beat_t b;
        b.row = r;
        b.data = d;
        sb_m.push_back(b);
    endtask

    task automatic push_e(input int r, input int d);
        beat_t b;
        b.row = r;
        b.data = d;
        sb_e.push_back(b);
    endtask

    // Score any beat accepted at the coming edge, then advance to the next sample point
    task automatic tick();
        beat_t b;
        if (sif_m.out_valid && sif_m.out_ready) begin
            if (sb_m.size() == 0) chk("m_extra_beat", 32'd1, 32'd0);
            else begin
                b = sb_m.pop_front();
                chk("m_beat_row", 32'(sif_m.out_row), 32'(b.row));
                chk("m_beat_data", 32'(sif_m.out_data), 32'(b.data));
            end
        end
        if (sif_e.out_valid && sif_e.out_ready) begin
            if (sb_e.size() == 0) chk("e_extra_beat", 32'd1, 32'd0);
            else begin
                b = sb_e.pop_front();
                chk("e_beat_row", 32'(sif_e.out_row), 32'(b.row));
                chk("e_beat_data", 32'(sif_e.out_data), 32'(b.data));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Expected control/stream view k cycles after start was sampled, no stall, ready=1
    function automatic ctl_t exp_ctl(input int k, input int ce, input int cx, input int dw,
                                     input int cr, input int nrows);
        ctl_t c;
        int   cs, cl, rs, dn;
        c  = '0;
        cs = ce + cx + 3;
        cl = 1 << dw;
        rs = cs + cl + 1;
        dn = rs + nrows * cr;
        if (k >= 1 && k <= dn) c.busy = 1'b1;
        if (k >= 1 && k <= ce) c.erase = 1'b1;
        if (k >= ce + 2 && k <= ce + cx + 1) c.expose = 1'b1;
        if (k >= cs && k < cs + cl) begin
            c.convert = 1'b1;
            c.bus_oe  = 1'b1;
            c.code    = 8'(k - cs);
        end
        if (k >= rs && k < dn) c.sel = 2'(1 << ((k - rs) / cr));
        if (k == dn) c.done = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            if (k == rs + cr * (r + 1)) begin
                c.valid = 1'b1;
                c.row   = 2'(r);
            end
        end
        return c;
    endfunction

    initial begin
        reset = 1'b1;
        m_start = 1'b0;
        e_start = 1'b0;
        sif_m.out_ready = 1'b1;
        sif_e.out_ready = 1'b1;
        th_m0 = 4'd9;
        th_m1 = 4'd3;
        th_e  = 2'd2;
        repeat (3) tick();
        chk("reset_m", 32'(obs_m), 32'd0);
        chk("reset_e", 32'(obs_e), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_m", 32'(obs_m), 32'd0);

        // Single frame on both instances, full per-cycle trace
        push_m(0, 9);
        push_m(1, 3);
        push_e(0, 2);
        m_start = 1'b1;
        e_start = 1'b1;
        tick();
        m_start = 1'b0;
        e_start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            chk("m_trace", 32'(obs_m), 32'(exp_ctl(k, 5, 10, 4, 3, 2)));
            chk("e_trace", 32'(obs_e), 32'(exp_ctl(k, 1, 1, 2, 1, 1)));
            tick();
        end
        chk("frame1_sb_m_empty", 32'(sb_m.size()), 32'd0);
        chk("frame1_sb_e_empty", 32'(sb_e.size()), 32'd0);

        // Backpressure: ready low in cycles 36..44 stalls row1's capture until cycle 45
        th_m0 = 4'd12;
        th_m1 = 4'd5;
        push_m(0, 12);
        push_m(1, 5);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (k <= 35) begin
                chk("bp_trace", 32'(obs_m), 32'(exp_ctl(k, 5, 10, 4, 3, 2)));
            end else if (k <= 48) begin
                chk("bp_sel", 32'(m_read_sel), (k <= 37) ? 32'd1 : ((k <= 45) ? 32'd2 : 32'd0));
                chk("bp_done", 32'(m_frame_done), (k == 46) ? 32'd1 : 32'd0);
                chk("bp_valid", 32'(sif_m.out_valid), (k >= 38 && k <= 46) ? 32'd1 : 32'd0);
            end
            if (k == 36) sif_m.out_ready = 1'b0;
            if (k == 45) sif_m.out_ready = 1'b1;
            tick();
        end
        chk("bp_idle", 32'(m_busy), 32'd0);
        chk("bp_sb_empty", 32'(sb_m.size()), 32'd0);

        // start pulsed during EXPOSE is ignored
        th_m0 = 4'd7;
        th_m1 = 4'd1;
        push_m(0, 7);
        push_m(1, 1);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 50; k++) begin
            chk("pulse_trace", 32'(obs_m), 32'(exp_ctl(k, 5, 10, 4, 3, 2)));
            if (m_frame_done) dones++;
            if (k == 10) m_start = 1'b1;
            if (k == 11) m_start = 1'b0;
            tick();
        end
        chk("pulse_one_done", 32'(dones), 32'd1);
        chk("pulse_sb_empty", 32'(sb_m.size()), 32'd0);

        // Reset in the middle of CONVERT
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        repeat (24) tick();
        chk("rst_pre_code", 32'(m_bus_out), 32'd7);
        chk("rst_pre_conv", 32'(m_convert), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_m", 32'(obs_m), 32'd0);
        chk("rst_async_e", 32'(obs_e), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_stays_idle", 32'(obs_m), 32'd0);
        end

`ifdef PIXCTRL_CONT_EN
        // start held: three back-to-back frames, DONE chains into ERASE
        th_m0 = 4'd4;
        th_m1 = 4'd11;
        for (int f = 0; f < 3; f++) begin
            push_m(0, 4);
            push_m(1, 11);
        end
        m_start = 1'b1;
        tick();
        dones = 0;
        fin = 1'b0;
        exp_erase = 1'b0;
        for (int k = 1; k <= 200 && !fin; k++) begin
            if (exp_erase) begin
                chk("cont_erase_after_done", 32'(m_erase), 32'd1);
                exp_erase = 1'b0;
            end
            chk("cont_busy", 32'(m_busy), 32'd1);
            if (m_frame_done) begin
                dones++;
                if (dones < 3) exp_erase = 1'b1;
                else begin
                    m_start = 1'b0;
                    fin = 1'b1;
                end
            end
            tick();
        end
        m_start = 1'b0;
        chk("cont_idle", 32'(m_busy), 32'd0);
        chk("cont_dones", 32'(dones), 32'd3);
`else
        // start held: single-shot returns to IDLE after DONE before the next frame
        th_m0 = 4'd4;
        th_m1 = 4'd11;
        push_m(0, 4);
        push_m(1, 11);
        m_start = 1'b1;
        tick();
        fin = 1'b0;
        for (int k = 1; k <= 100 && !fin; k++) begin
            if (m_frame_done) fin = 1'b1;
            tick();
        end
        chk("ss_done_seen", 32'(fin), 32'd1);
        chk("ss_idle_after_done", 32'(m_busy), 32'd0);
        push_m(0, 4);
        push_m(1, 11);
        tick();
        chk("ss_restart_erase", 32'(m_erase), 32'd1);
        m_start = 1'b0;
        repeat (60) tick();
        chk("ss_idle", 32'(m_busy), 32'd0);
`endif
        repeat (3) tick();
        chk("final_sb_m_empty", 32'(sb_m.size()), 32'd0);
        chk("final_sb_e_empty", 32'(sb_e.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
